store_buffer: RTL
=================

# store_buffer

Posted-write buffer between the core's data-memory write port and a slower handshaked memory bus. The core issues single-cycle stores (`write`, `write_address`, `DATA_out`, `size`). The block converts each store into a word-aligned, byte-lane-enabled bus write, queues it in a FIFO, and drains it over a req/ack handshake. It also flags loads that hit a still-pending store word, so the core can stall the load in a later integration.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries; power of two, minimum 2.

Ports:
- `clk`  in  1: single clock; everything is rising-edge.
- `reset`  in  1: synchronous, active-low.
- `write`  in  1: core store strobe, one store per asserted cycle.
- `write_address`  in  32: store byte address.
- `DATA_out`  in  32: store data, right-aligned.
- `size`  in  2: store size. 01 = byte, 10 = half, 11 = word, 00 = ignored (no enqueue).
- `read`  in  1: core load strobe.
- `read_address`  in  32: load byte address.
- `read_hazard`  out  1: load word matches a pending store (combinational).
- `mem_req`  out  1: bus write request (registered).
- `mem_addr`  out  32: word address, with [1:0] = 00.
- `mem_wdata`  out  32: lane-replicated data.
- `mem_be`  out  4: byte enables.
- `mem_ack`  in  1: bus accepts the current write.
- `full`, `empty`  out  1: FIFO status.
- `count`  out  $clog2(DEPTH)+1: occupancy.
- `overflow`  out  1: sticky; a store was dropped because the FIFO was full.
- `misaligned`  out  1: one-cycle pulse; a store was dropped as misaligned.

## Operation
- **Lane formatting at enqueue.** `k` = `write_address[1:0]`.
  - Byte: `mem_be` = 1<<k; `mem_wdata` = {4{DATA_out[7:0]}}.
  - Half: k=0 gives `mem_be` 0011, k=2 gives 1100; `mem_wdata` = {2{DATA_out[15:0]}}.
  - Word: `mem_be` 1111; `mem_wdata` = `DATA_out`.
  - Each entry stores {addr[31:2], wdata, be}.
- **Misaligned stores.** A half with k odd, or a word with k≠0, is not enqueued. `misaligned` pulses the next cycle.
- **Enqueue when not full.** If `write` is high, `size`≠00, the store is aligned, and `count`<DEPTH, the entry is pushed at the edge.
- **Enqueue when full.**
  - If a pop happens in the same cycle (`mem_req`&&`mem_ack`), the push is still accepted and `count` is unchanged.
  - Otherwise the store is dropped and `overflow` is set, held until reset.
- **Drain FSM.**
  - IDLE: `mem_req`=0. Go to REQ when `count`>0 at an edge.
  - REQ: `mem_req`=1 and the head entry drives `mem_addr`/`mem_wdata`/`mem_be`, held stable until `mem_ack` is sampled high.
  - On ack: pop. Stay in REQ if entries remain after the pop (this includes an entry pushed that same cycle); otherwise go to IDLE.
  - `mem_ack` is ignored while `mem_req`=0.
- **Read hazard.** `read_hazard` = `read` && (some valid entry has addr[31:2] equal to `read_address[31:2]`). All entries are compared, including the head currently on the bus.
- **Pointers.** Read and write pointers wrap modulo DEPTH. `full` = (`count`==DEPTH); `empty` = (`count`==0).

## Timing
- **Reset values.** While `reset`=0 at an edge: FIFO cleared, FSM IDLE, `mem_req`=0, `mem_addr`/`mem_wdata`/`mem_be`=0, `count`=0, `empty`=1, `full`=0, `overflow`=0, `misaligned`=0.
- **Store-to-request latency.** A store accepted at edge N with the FIFO empty raises `mem_req` in cycle N+1.
- **Back-to-back drain.** Ack sampled at edge M pops the head. The next entry is presented with `mem_req` still high in cycle M+1, giving one write per cycle at zero wait states.
- **Reset mid-transfer.** Asserting reset during REQ abandons the outstanding write: `mem_req` is low after that edge and queued stores are lost.
- **Status timing.** `count`, `full` and `empty` update at the push/pop edge. `read_hazard` reflects FIFO contents registered before the current edge.

## Test plan
- **Single byte store.** `write`=1, addr 0x1003, data 0x000000AB, size 01 → next cycle `mem_req`=1, `mem_addr`=0x1000, `mem_be`=1000, `mem_wdata`=0xABABABAB. Ack → `empty`=1, `mem_req`=0.
- **Fill and overflow.** Hold `mem_ack`=0 and issue 5 word stores with DEPTH=4 → `full`=1 after the 4th; the 5th is dropped and `overflow`=1. Then ack 4 times → words 1–4 drain in order.
- **Push and pop at full.** With the FIFO full, assert `write` and `mem_ack` in the same cycle → `count` stays 4 and the new entry drains last.
- **Misaligned stores.** Half store at 0x2001, then word store at 0x2002 → no enqueue, `misaligned` pulses for each, `count` stays 0.
- **Read hazard.** Pending store to 0x3004 with ack held low; `read`=1 at 0x3006 → `read_hazard`=1. `read`=1 at 0x3008 → `read_hazard`=0. After the ack, 0x3006 → `read_hazard`=0.
- **Reset mid-transfer.** Two entries queued with `mem_req`=1; drive `reset`=0 for one edge → `mem_req`=0, `count`=0, `overflow`=0; `mem_ack` afterwards has no effect.

Source files
------------

// File: rtl/store_buffer.sv
// Posted-write store buffer: formats core stores into word-aligned byte-lane bus
// writes, queues them in a FIFO, drains them over req/ack and flags load hazards.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     write,
  input  logic [31:0]              write_address,
  input  logic [31:0]              DATA_out,
  input  logic [1:0]               size,
  input  logic                     read,
  input  logic [31:0]              read_address,
  output logic                     read_hazard,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_be,
  input  logic                     mem_ack,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     misaligned
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

  function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] k);
    case (sz)
      2'b01:   lane_be = 4'b0001 << k;
      2'b10:   lane_be = k[1] ? 4'b1100 : 4'b0011;
      2'b11:   lane_be = 4'b1111;
      default: lane_be = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b01:   lane_data = {4{d[7:0]}};
      2'b10:   lane_data = {2{d[15:0]}};
      default: lane_data = d;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] k);
    case (sz)
      2'b10:   is_misaligned = k[0];
      2'b11:   is_misaligned = (k != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

  state_t            state, state_next;
  logic [29:0]       addr_mem [DEPTH];
  logic [31:0]       data_mem [DEPTH];
  logic [3:0]        be_mem   [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count_next;
  logic              bad_align, store_ok, pop, push, drop, hit;
  logic              unused_bits;

  assign unused_bits = ^read_address[1:0];
  assign bad_align   = is_misaligned(size, write_address[1:0]);
  assign store_ok    = write && (size != 2'b00) && !bad_align;
  assign pop         = mem_req && mem_ack;
  // A full FIFO still accepts a store when the head leaves in the same cycle.
  assign push        = store_ok && (!full || pop);
  assign drop        = store_ok && full && !pop;
  assign full        = (count == DEPTH_C);
  assign empty       = (count == CW'(0));
  assign mem_addr    = mem_req ? {addr_mem[rd_ptr], 2'b00} : 32'h0000_0000;
  assign mem_wdata   = mem_req ? data_mem[rd_ptr] : 32'h0000_0000;
  assign mem_be      = mem_req ? be_mem[rd_ptr] : 4'b0000;
  assign read_hazard = read && hit;

  // Occupancy after this edge's push/pop.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Drain FSM next state: request whenever entries remain after this edge.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (count_next != CW'(0)) state_next = S_REQ; else state_next = S_IDLE;
      S_REQ:   if (pop && (count_next == CW'(0))) state_next = S_IDLE; else state_next = S_REQ;
      default: state_next = S_IDLE;
    endcase
  end

  // Compare the load word against every valid entry, head included.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hit = hit | (valid[i] && (addr_mem[i] == read_address[31:2]));
    end
  end

  // FIFO storage, pointers, FSM state and status flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      mem_req    <= 1'b0;
      count      <= CW'(0);
      wr_ptr     <= PW'(0);
      rd_ptr     <= PW'(0);
      valid      <= '0;
      overflow   <= 1'b0;
      misaligned <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem[i] <= 30'h0;
        data_mem[i] <= 32'h0000_0000;
        be_mem[i]   <= 4'b0000;
      end
    end else begin
      state      <= state_next;
      mem_req    <= (state_next == S_REQ);
      count      <= count_next;
      misaligned <= write && bad_align;
      if (drop) overflow <= 1'b1;
      if (pop) begin
        rd_ptr        <= rd_ptr + PW'(1);
        valid[rd_ptr] <= 1'b0;
      end
      // Push after pop so a full-FIFO push into the departing head slot keeps it valid.
      if (push) begin
        addr_mem[wr_ptr] <= write_address[31:2];
        data_mem[wr_ptr] <= lane_data(size, DATA_out);
        be_mem[wr_ptr]   <= lane_be(size, write_address[1:0]);
        valid[wr_ptr]    <= 1'b1;
        wr_ptr           <= wr_ptr + PW'(1);
      end
    end
  end

endmodule
